// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the rvMagic memory port arbiter: FSM states, owners, mode encodings.
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} arb_state_e;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_e;

  localparam logic MEM_MODE_WORD = 1'b0;
  localparam logic MEM_MODE_BYTE = 1'b1;
  localparam int unsigned STARVE_MAX_DEF = 4;
endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data ports; data has priority until the fetch has
// watched STARVE_MAX data grants go by, then the fetch is forced through.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_elig_i,
  input  logic       d_elig_i,
  input  logic       grant_i,
  output arb_owner_e owner_o
);
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved;

  assign starved = (starve_q == CNT_W'(STARVE_MAX));
  assign owner_o = (d_elig_i && !(if_elig_i && starved)) ? OWN_D : OWN_IF;

  always_comb begin
    starve_d = starve_q;
    if (grant_i) begin
      if (owner_o == OWN_IF) begin
        starve_d = '0;
      end else if (if_elig_i && !starved) begin
        starve_d = starve_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one req/gnt/rvalid memory bus,
// routes responses back and stalls the pipeline until every request of the step is served.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic              d_mode,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_n
);
  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d, pick_owner;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              we_q, we_d, mode_q, mode_d;
  logic              if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic              if_done_q, if_done_d, d_done_q, d_done_d;
  logic              d_req, if_elig, d_elig, grant;

  // A port pulsing valid this cycle is finished for the step even though its done flag lags.
  assign d_req   = d_rd | d_wr;
  assign if_elig = if_req & ~if_done_q & ~if_valid_q;
  assign d_elig  = d_req & ~d_done_q & ~d_valid_q;
  assign grant   = (state_q == IDLE) & (if_elig | d_elig);
  assign stall_n = (~if_req | if_done_q | if_valid_q) & (~d_req | d_done_q | d_valid_q);

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_elig_i(if_elig),
    .d_elig_i (d_elig),
    .grant_i  (grant),
    .owner_o  (pick_owner)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    mode_d     = mode_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ISSUE;
          owner_d = pick_owner;
          if (pick_owner == OWN_D) begin
            addr_d  = d_addr;
            we_d    = d_wr;
            mode_d  = d_mode ? MEM_MODE_BYTE : MEM_MODE_WORD;
            wdata_d = d_wr ? d_wdata : '0;
          end else begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            mode_d  = MEM_MODE_WORD;
            wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          if (we_q) begin
            d_valid_d = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            d_rdata_d = mem_rdata;
            d_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if_done_d = stall_n ? 1'b0 : (if_done_q | if_valid_q);
    d_done_d  = stall_n ? 1'b0 : (d_done_q | d_valid_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      mode_q     <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      mode_q     <= mode_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
    end
  end

  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = mem_req & we_q;
  assign mem_mode  = mem_req & mode_q;
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
endmodule
